// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction loader slice.
package mips_pkg;
  localparam int NB_BYTE = 8;
  localparam int NB_DATA = 4 * NB_BYTE;

  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } loader_state_t;
endpackage

// File: rtl/instruction_loader_if.sv
// UART-byte input side and instruction-memory write / status side of the loader.
// o_chk_err exists only when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
interface instruction_loader_if #(
  parameter int NB_ADDR = 8
);
  import mips_pkg::*;

  logic               i_start;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_wr_en;
  logic [NB_ADDR-1:0] o_wr_addr;
  logic [NB_DATA-1:0] o_wr_data;
  logic               o_loading;
  logic               o_done;
  logic               o_overflow;
  logic [NB_ADDR:0]   o_word_count;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic               o_chk_err;

  modport master (
    input  i_start, i_rx_data, i_rx_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_loading, o_done, o_overflow,
           o_word_count, o_chk_err
  );

  modport slave (
    output i_start, i_rx_data, i_rx_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_loading, o_done, o_overflow,
           o_word_count, o_chk_err
  );
`else
  modport master (
    input  i_start, i_rx_data, i_rx_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_loading, o_done, o_overflow,
           o_word_count
  );

  modport slave (
    output i_start, i_rx_data, i_rx_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_loading, o_done, o_overflow,
           o_word_count
  );
`endif
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Packs big-endian bytes into words; word_valid flags the push that completes a word.
module word_assembler
  import mips_pkg::*;
#(
  parameter int NB_BYTE = mips_pkg::NB_BYTE,
  parameter int NB_DATA = mips_pkg::NB_DATA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic [NB_BYTE-1:0] data,
  output logic [NB_DATA-1:0] word,
  output logic               word_valid
);
  logic [NB_DATA-NB_BYTE-1:0] shift;
  logic [1:0]                 count;

  // The completed word is presented combinationally so the caller can register it on the 4th byte.
  assign word       = {shift, data};
  assign word_valid = push && (count == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      count <= '0;
    end else if (clear) begin
      shift <= '0;
      count <= '0;
    end else if (push) begin
      shift <= {shift[NB_DATA-2*NB_BYTE-1:0], data};
      count <= count + 2'd1;
    end
  end
endmodule

// File: rtl/instruction_loader.sv
// Loads a UART byte stream into instruction memory until HALT or memory full.
// Optional feature: INSTRUCTION_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and o_chk_err.
module instruction_loader
  import mips_pkg::*;
#(
  parameter int NB_DATA = mips_pkg::NB_DATA,
  parameter int NB_BYTE = mips_pkg::NB_BYTE,
  parameter int NB_ADDR = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  instruction_loader_if.master bus
);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  loader_state_t      state;
  logic [NB_ADDR-1:0] addr;
  logic               push;
  logic [NB_DATA-1:0] word;
  logic               word_valid;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] checksum;
`endif

  // Start has priority over a coincident byte, which is simply dropped.
  assign push = bus.i_rx_valid && !bus.i_start && (state == LOAD);

  word_assembler #(
    .NB_BYTE(NB_BYTE),
    .NB_DATA(NB_DATA)
  ) u_word_assembler (
    .clk       (i_clock),
    .rst       (i_reset),
    .clear     (bus.i_start),
    .push      (push),
    .data      (bus.i_rx_data),
    .word      (word),
    .word_valid(word_valid)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state            <= IDLE;
      addr             <= '0;
      bus.o_wr_en      <= 1'b0;
      bus.o_wr_addr    <= '0;
      bus.o_wr_data    <= '0;
      bus.o_loading    <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_overflow   <= 1'b0;
      bus.o_word_count <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      checksum         <= '0;
      bus.o_chk_err    <= 1'b0;
`endif
    end else begin
      bus.o_wr_en <= 1'b0;
      if (bus.i_start) begin
        state            <= LOAD;
        addr             <= '0;
        bus.o_loading    <= 1'b1;
        bus.o_done       <= 1'b0;
        bus.o_overflow   <= 1'b0;
        bus.o_word_count <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        checksum         <= '0;
        bus.o_chk_err    <= 1'b0;
`endif
      end else begin
        case (state)
          LOAD: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            if (push) checksum <= checksum ^ bus.i_rx_data;
`endif
            // Status changes on the same edge that registers the final write.
            if (word_valid) begin
              bus.o_wr_en      <= 1'b1;
              bus.o_wr_addr    <= addr;
              bus.o_wr_data    <= word;
              addr             <= addr + 1'b1;
              bus.o_word_count <= bus.o_word_count + 1'b1;
              if (word == HALT_WORD) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                state         <= CHECK;
`else
                state         <= DONE;
                bus.o_loading <= 1'b0;
                bus.o_done    <= 1'b1;
`endif
              end else if (addr == LAST_ADDR) begin
                state          <= DONE;
                bus.o_loading  <= 1'b0;
                bus.o_done     <= 1'b1;
                bus.o_overflow <= 1'b1;
              end
            end
          end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          CHECK: begin
            if (bus.i_rx_valid) begin
              bus.o_chk_err <= (bus.i_rx_data != checksum);
              state         <= DONE;
              bus.o_loading <= 1'b0;
              bus.o_done    <= 1'b1;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader (NB_ADDR=2): vector table, corner sequences, random loads.
// Also exercises the checksum path when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;
  import mips_pkg::*;

  localparam int NB_ADDR = 2;
  localparam int DEPTH   = 1 << NB_ADDR;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [NB_ADDR-1:0] addr;
    logic [31:0]        data;
  } wr_t;
  typedef struct {
    int           n;
    logic [135:0] bits;
    int           expWrites;
    logic [31:0]  expLast;
    bit           expOvf;
    bit           expHalt;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  seen[$];
  int   seenCyc[$];
  int   byteCyc[$];
  vec_t vecs[6];

  instruction_loader_if #(.NB_ADDR(NB_ADDR)) bus ();

  instruction_loader #(.NB_ADDR(NB_ADDR)) dut (
    .i_clock(clock),
    .i_reset(reset),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor samples on the falling edge, away from the register updates.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.o_wr_en === 1'b1) begin
      seen.push_back({bus.o_wr_addr, bus.o_wr_data});
      seenCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    reset          = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulseStart();
    seen.delete();
    seenCyc.delete();
    byteCyc.delete();
    bus.i_start = 1'b1;
    @(negedge clock);
    bus.i_start = 1'b0;
  endtask

  task automatic applyStimulus(input byte_q_t bytes, input int maxGap);
    int gap;
    foreach (bytes[i]) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = bytes[i];
      byteCyc.push_back(cyc);
      @(negedge clock);
      bus.i_rx_valid = 1'b0;
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      repeat (gap) @(negedge clock);
    end
    repeat (3) @(negedge clock);
  endtask

  // Reference: split the accepted stream into words and stop at HALT, full memory or checksum byte.
  task automatic modelLoad(input byte_q_t bytes, output wr_t exp[$], output bit ovf,
                           output bit fin, output bit chkErr);
    logic [31:0] w;
    logic [7:0]  x;
    int          n;
    bit          halted;
    w = '0; x = '0; n = 0; halted = 1'b0;
    exp.delete();
    ovf = 1'b0; fin = 1'b0; chkErr = 1'b0;
    foreach (bytes[i]) begin
      if (halted) begin
        chkErr = (bytes[i] != x);
        fin    = 1'b1;
        break;
      end
      x = x ^ bytes[i];
      w = {w[23:0], bytes[i]};
      n++;
      if (n % 4 == 0) begin
        exp.push_back({NB_ADDR'(exp.size()), w});
        if (w == 32'hFFFF_FFFF) begin
          if (CHK) halted = 1'b1;
          else begin
            fin = 1'b1;
            break;
          end
        end else if (exp.size() == DEPTH) begin
          ovf = 1'b1;
          fin = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic verifyLoad(input string tag, input byte_q_t bytes);
    wr_t exp[$];
    bit  ovf, fin, chkErr;
    modelLoad(bytes, exp, ovf, fin, chkErr);
    checkOutput({tag, " write count"}, seen.size(), exp.size());
    foreach (exp[i]) if (i < seen.size()) checkOutput({tag, " write"}, seen[i], exp[i]);
    checkOutput({tag, " word_count"}, bus.o_word_count, exp.size());
    checkOutput({tag, " overflow"}, bus.o_overflow, ovf);
    checkOutput({tag, " done"}, bus.o_done, fin);
    checkOutput({tag, " loading"}, bus.o_loading, !fin);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    checkOutput({tag, " chk_err"}, bus.o_chk_err, chkErr);
`endif
  endtask

  initial begin
    byte_q_t q;
    vec_t    v;
    bit      expDone;

    vecs[0] = '{8,  136'h20010005_FFFFFFFF, 2, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[1] = '{4,  136'hFFFFFFFF, 1, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[2] = '{8,  136'h11111111_22222222, 2, 32'h2222_2222, 1'b0, 1'b0};
    vecs[3] = '{17, {17{8'h11}}, 4, 32'h1111_1111, 1'b1, 1'b0};
    vecs[4] = '{16, 136'h01020304_05060708_090A0B0C_FFFFFFFF, 4, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[5] = '{6,  136'h00000001_ABCD, 1, 32'h0000_0001, 1'b0, 1'b0};

    applyReset();
    checkOutput("reset wr_en", bus.o_wr_en, 0);
    checkOutput("reset wr_addr", bus.o_wr_addr, 0);
    checkOutput("reset wr_data", bus.o_wr_data, 0);
    checkOutput("reset loading", bus.o_loading, 0);
    checkOutput("reset done", bus.o_done, 0);
    checkOutput("reset overflow", bus.o_overflow, 0);
    checkOutput("reset word_count", bus.o_word_count, 0);

    // Vector table: back-to-back bytes, constant expectations.
    foreach (vecs[k]) begin
      v = vecs[k];
      q.delete();
      for (int i = 0; i < v.n; i++) q.push_back(v.bits[(v.n - 1 - i) * 8 +: 8]);
      pulseStart();
      applyStimulus(q, 0);
      expDone = v.expOvf || (v.expHalt && !CHK);
      checkOutput($sformatf("vec%0d writes", k), seen.size(), v.expWrites);
      if (seen.size() > 0)
        checkOutput($sformatf("vec%0d last data", k), seen[seen.size()-1].data, v.expLast);
      foreach (seen[i]) checkOutput($sformatf("vec%0d addr%0d", k, i), seen[i].addr, i);
      checkOutput($sformatf("vec%0d word_count", k), bus.o_word_count, v.expWrites);
      checkOutput($sformatf("vec%0d overflow", k), bus.o_overflow, v.expOvf);
      checkOutput($sformatf("vec%0d done", k), bus.o_done, expDone);
      checkOutput($sformatf("vec%0d loading", k), bus.o_loading, !expDone);
    end

    // Write latency on back-to-back strobes: one cycle after each 4th byte.
    pulseStart();
    q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus(q, 0);
    checkOutput("b2b writes", seen.size(), 2);
    if (seen.size() >= 2) begin
      checkOutput("b2b latency0", seenCyc[0], byteCyc[3] + 1);
      checkOutput("b2b latency1", seenCyc[1], byteCyc[7] + 1);
      checkOutput("b2b data0", seen[0].data, 32'h2001_0005);
      checkOutput("b2b data1", seen[1].data, 32'h1234_5678);
    end

    // Restart after a partial word.
    pulseStart();
    q = '{8'h20, 8'h01};
    applyStimulus(q, 0);
    pulseStart();
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    applyStimulus(q, 0);
    verifyLoad("restart", q);

    // Reset right after the edge that accepts a 4th byte cancels the write.
    pulseStart();
    q = '{8'h12, 8'h34, 8'h56};
    applyStimulus(q, 0);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'h78;
    @(posedge clock);
    #1;
    reset          = 1'b1;
    bus.i_rx_valid = 1'b0;
    @(negedge clock);
    checkOutput("rst wr_en", bus.o_wr_en, 0);
    checkOutput("rst loading", bus.o_loading, 0);
    checkOutput("rst word_count", bus.o_word_count, 0);
    checkOutput("rst wr_data", bus.o_wr_data, 0);
    checkOutput("rst writes seen", seen.size(), 0);
    reset = 1'b0;
    @(negedge clock);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(q, 0);
    checkOutput("idle ignores bytes", seen.size(), 0);
    checkOutput("idle loading", bus.o_loading, 0);

    // Start and byte in the same cycle: byte is dropped.
    seen.delete();
    bus.i_start    = 1'b1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'hAA;
    @(negedge clock);
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    applyStimulus(q, 0);
    verifyLoad("start collision", q);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    pulseStart();
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    applyStimulus(q, 0);
    verifyLoad("checksum ok", q);
    pulseStart();
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    applyStimulus(q, 0);
    verifyLoad("checksum bad", q);
`endif

    // Random programs with HALT words mixed in and random gaps.
    for (int r = 0; r < 40; r++) begin
      int nWords;
      q.delete();
      nWords = int'($urandom_range(6, 1));
      for (int w = 0; w < nWords; w++) begin
        if ($urandom_range(3, 0) == 0) repeat (4) q.push_back(8'hFF);
        else repeat (4) q.push_back(8'($urandom));
      end
      repeat ($urandom_range(3, 0)) q.push_back(8'($urandom));
      pulseStart();
      applyStimulus(q, 2);
      verifyLoad($sformatf("random%0d", r), q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
